// File: rtl/softmax_div_issuer.sv
// Softmax normaliser front end: gathers one vector of exp values, sums them, then
// drives one fixed-point division per element and streams the quotients in index order.
module softmax_div_issuer #(
    parameter int VEC_LEN = 8,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic             div_start,
    output logic [15:0]      div_num,
    output logic [23:0]      div_den,
    input  logic [15:0]      div_quotient,
    input  logic             div_valid,
    output logic             out_valid,
    output logic [15:0]      out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [23:0]      sum_q, sum_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             in_ready_q;
    logic             err_q, err_d;
    logic [15:0]      vec_q [VEC_LEN];

    logic             accept;
    logic [15:0]      clamped;
    logic [24:0]      sum_ext;
    logic             timed_out;
    logic             finish_elem;

    // Negative exp values are treated as zero weight in both the buffer and the sum.
    assign clamped     = in_data[15] ? 16'h0000 : in_data;
    assign sum_ext     = {1'b0, sum_q} + {9'b0, clamped};
    assign accept      = (state_q == S_LOAD) && in_ready_q && in_valid;
    assign timed_out   = (state_q == S_WAIT) && !div_valid && (timer_q == TMR_MAX);
    assign finish_elem = (state_q == S_WAIT) && (div_valid || (timer_q == TMR_MAX));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        timer_d   = timer_q;
        err_d     = err_q;
        div_start = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    sum_d = sum_ext[24] ? 24'hFFFFFF : sum_ext[23:0];
                    if (cnt_q == '0) begin
                        err_d = 1'b0;
                    end
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                div_start = 1'b1;
                timer_d   = '0;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                // A completion arriving on the timeout cycle still counts as a real result.
                if (finish_elem) begin
                    if (timed_out) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        sum_d   = '0;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            timer_q    <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            in_ready_q <= (state_d == S_LOAD);
        end
    end

    // Element storage carries no reset; its contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (accept) begin
            vec_q[cnt_q] <= clamped;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign err       = err_q;
    assign div_num   = (state_q == S_LOAD) ? 16'h0000 : vec_q[idx_q];
    assign div_den   = (state_q == S_LOAD) ? 24'h000000 : sum_q;

    assign out_valid = finish_elem;
    assign out_data  = (finish_elem && div_valid) ? div_quotient : 16'h0000;
    assign out_idx   = finish_elem ? idx_q : '0;
    assign out_last  = finish_elem && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_softmax_div_issuer.sv
// Directed bench for softmax_div_issuer with a behavioural divider model and
// hand-computed expectations for each vector.
module tb_softmax_div_issuer;

    localparam int VEC_LEN = 8;
    localparam int IDX_W   = 3;
    localparam int TIMEOUT = 31;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [15:0]      in_data = 16'h0000;
    logic             in_ready;
    logic             div_start;
    logic [15:0]      div_num;
    logic [23:0]      div_den;
    logic [15:0]      div_quotient = 16'h0000;
    logic             div_valid = 1'b0;
    logic             out_valid;
    logic [15:0]      out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             busy;
    logic             err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          divDelay    = 18;
    int          withholdIdx = -1;
    int          startsInVec = 0;
    logic        pending     = 1'b0;
    int          pendCnt     = 0;
    logic [15:0] pendQuot    = 16'h0000;

    logic [15:0]      obsData [$];
    logic [IDX_W-1:0] obsIdx [$];
    logic             obsLast [$];
    int               obsCycle [$];
    int               acceptCycles [$];
    int               startCycles [$];
    logic [15:0]      startNum [$];
    logic [23:0]      startDen [$];
    logic             errSeen = 1'b0;
    int               errCycle = 0;

    logic [15:0] expVec [VEC_LEN];

    softmax_div_issuer #(
        .VEC_LEN(VEC_LEN),
        .IDX_W  (IDX_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .div_start   (div_start),
        .div_num     (div_num),
        .div_den     (div_den),
        .div_quotient(div_quotient),
        .div_valid   (div_valid),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [15:0] divModel(input logic [15:0] n, input logic [23:0] d);
        logic [33:0] wide;
        if (d == 24'h0) return 16'h03FF;
        wide = {8'b0, n, 10'b0} / {10'b0, d};
        return wide[15:0];
    endfunction

    // Divider model: answers divDelay cycles after the start cycle, optionally never for one element.
    always @(posedge clk) begin
        #1;
        div_valid    = 1'b0;
        div_quotient = 16'h0000;
        if (!rst_n) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                pendCnt--;
                if (pendCnt == 0) begin
                    div_valid    = 1'b1;
                    div_quotient = pendQuot;
                    pending      = 1'b0;
                end
            end
            if (div_start) begin
                startCycles.push_back(cyc);
                startNum.push_back(div_num);
                startDen.push_back(div_den);
                if (startsInVec != withholdIdx) begin
                    pending  = 1'b1;
                    pendCnt  = divDelay;
                    pendQuot = divModel(div_num, div_den);
                end
                startsInVec++;
            end
        end
    end

    // Output and handshake monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_valid) begin
            obsData.push_back(out_data);
            obsIdx.push_back(out_idx);
            obsLast.push_back(out_last);
            obsCycle.push_back(cyc);
        end
        if (in_valid && in_ready) acceptCycles.push_back(cyc);
        if (err && !errSeen) begin
            errSeen  = 1'b1;
            errCycle = cyc;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearObs();
        obsData.delete();
        obsIdx.delete();
        obsLast.delete();
        obsCycle.delete();
        acceptCycles.delete();
        startCycles.delete();
        startNum.delete();
        startDen.delete();
        startsInVec = 0;
        errSeen     = 1'b0;
    endtask

    // Presents one value, holds it until accepted, then idles for gap cycles.
    task automatic applyStimulus(input logic [15:0] v, input int gap);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        while (!in_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitOutputs(input int n, input int budget);
        int waited = 0;
        while (obsData.size() < n && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (obsData.size() < n) checkOutput("wait_outputs", 64'(obsData.size()), 64'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic verifyVector(input string name, input logic [23:0] expDen, input int expSpacing);
        checkOutput({name, "_outs"}, 64'(obsData.size()), 64'(VEC_LEN));
        checkOutput({name, "_starts"}, 64'(startDen.size()), 64'(VEC_LEN));
        for (int i = 0; i < obsData.size() && i < VEC_LEN; i++) begin
            checkOutput($sformatf("%s_data%0d", name, i), 64'(obsData[i]), 64'(expVec[i]));
            checkOutput($sformatf("%s_idx%0d", name, i), 64'(obsIdx[i]), 64'(i));
            checkOutput($sformatf("%s_last%0d", name, i), 64'(obsLast[i]), 64'(i == VEC_LEN - 1));
        end
        for (int i = 0; i < startDen.size() && i < VEC_LEN; i++) begin
            checkOutput($sformatf("%s_den%0d", name, i), 64'(startDen[i]), 64'(expDen));
            if (expSpacing > 0 && i > 0)
                checkOutput($sformatf("%s_spacing%0d", name, i),
                            64'(startCycles[i] - startCycles[i-1]), 64'(expSpacing));
        end
    endtask

    initial begin
        logic [15:0] gapVals [VEC_LEN];
        int          gapLens [VEC_LEN];
        logic [15:0] gapNums [VEC_LEN];
        int          waited;

        $display("[TB] reset behaviour");
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ctrl", 64'({in_ready, div_start, out_valid, out_last, busy, err, out_idx}), 64'd0);
        checkOutput("reset_data", 64'({div_num, div_den, out_data}), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_low_at_release", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_release", 64'(in_ready), 64'd1);

        $display("[TB] uniform vector");
        clearObs();
        divDelay = 18;
        withholdIdx = -1;
        for (int i = 0; i < VEC_LEN; i++) applyStimulus(16'h0400, 0);
        waitOutputs(VEC_LEN, 400);
        for (int i = 0; i < VEC_LEN; i++) expVec[i] = 16'h0080;
        verifyVector("uniform", 24'h002000, 19);
        checkOutput("uniform_err", 64'(err), 64'd0);

        $display("[TB] zero vector");
        clearObs();
        divDelay = 1;
        for (int i = 0; i < VEC_LEN; i++) applyStimulus(16'h0000, 0);
        waitOutputs(VEC_LEN, 100);
        for (int i = 0; i < VEC_LEN; i++) expVec[i] = 16'h03FF;
        verifyVector("zero", 24'h000000, 2);
        checkOutput("zero_err", 64'(err), 64'd0);

        $display("[TB] gaps, clamp and held ninth value");
        clearObs();
        divDelay = 18;
        gapVals = '{16'h0100, 16'h8400, 16'h0300, 16'h0200, 16'h0200, 16'h0400, 16'h0100, 16'h0300};
        gapLens = '{1, 2, 0, 3, 0, 1, 2, 0};
        gapNums = '{16'h0100, 16'h0000, 16'h0300, 16'h0200, 16'h0200, 16'h0400, 16'h0100, 16'h0300};
        expVec  = '{16'h0040, 16'h0000, 16'h00C0, 16'h0080, 16'h0080, 16'h0100, 16'h0040, 16'h00C0};
        for (int i = 0; i < VEC_LEN; i++) applyStimulus(gapVals[i], gapLens[i]);
        applyStimulus(16'h0400, 0);
        verifyVector("gaps", 24'h001000, 19);
        for (int i = 0; i < startNum.size() && i < VEC_LEN; i++)
            checkOutput($sformatf("gaps_num%0d", i), 64'(startNum[i]), 64'(gapNums[i]));
        checkOutput("ninth_accepts", 64'(acceptCycles.size()), 64'(VEC_LEN + 1));
        if (acceptCycles.size() > VEC_LEN && obsCycle.size() >= VEC_LEN)
            checkOutput("ninth_after_last", 64'(acceptCycles[VEC_LEN] - obsCycle[VEC_LEN-1]), 64'd1);
        checkOutput("gaps_err", 64'(err), 64'd0);

        $display("[TB] timeout on element 3");
        clearObs();
        withholdIdx = 3;
        for (int i = 1; i < VEC_LEN; i++) applyStimulus(16'h0400, 0);
        waitOutputs(VEC_LEN, 600);
        expVec = '{16'h0080, 16'h0080, 16'h0080, 16'h0000, 16'h0080, 16'h0080, 16'h0080, 16'h0080};
        verifyVector("timeout", 24'h002000, 0);
        if (startCycles.size() > 3 && obsCycle.size() > 3) begin
            checkOutput("timeout_latency", 64'(obsCycle[3] - startCycles[3]), 64'(TIMEOUT + 1));
            checkOutput("timeout_err_cycle", 64'(errCycle - obsCycle[3]), 64'd1);
        end
        checkOutput("timeout_err_sticky", 64'(err), 64'd1);

        $display("[TB] reset during element 5");
        clearObs();
        withholdIdx = -1;
        applyStimulus(16'h0200, 0);
        checkOutput("err_cleared_on_accept", 64'(err), 64'd0);
        for (int i = 1; i < VEC_LEN; i++) applyStimulus(16'h0200, 0);
        waited = 0;
        while (startDen.size() < 6 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("reset_mid_starts", 64'(startDen.size()), 64'd6);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_ctrl", 64'({busy, in_ready, out_valid, div_start}), 64'd0);
        checkOutput("async_reset_den", 64'(div_den), 64'd0);
        checkOutput("outs_before_reset", 64'(obsData.size()), 64'd5);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("no_out_after_reset", 64'(obsData.size()), 64'd5);

        $display("[TB] vector after reset");
        @(posedge clk);
        #1;
        clearObs();
        for (int i = 0; i < VEC_LEN; i++) applyStimulus(16'h0100, 0);
        waitOutputs(VEC_LEN, 400);
        for (int i = 0; i < VEC_LEN; i++) expVec[i] = 16'h0080;
        verifyVector("post_reset", 24'h000800, 19);
        checkOutput("post_reset_err", 64'(err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
